// File: rtl/imm_encoder_pkg.sv
// Shared format codes, NOP constant and request layout for the RV32I instruction encoder.
// The immediate extender uses the same format codes.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  localparam logic [31:0] INS_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  // True when bits [31:lsb] of v are all ones or all zeros, i.e. v fits a signed field of width lsb+1.
  function automatic logic upper_same(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << lsb;
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_encoder_imm_pack.sv
// Combinational packer: instruction fields and format to an RV32I word plus a legality flag.
// Illegal immediates and unknown formats give the NOP word.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [31:0] imm,
  output logic [31:0] ins,
  output logic        err
);

  logic [31:0] raw;
  logic        illegal;

  // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    raw     = 32'h0;
    illegal = 1'b1;
    case (fmt)
      FMT_I: begin
        raw     = {imm[11:0], rs1, f3, rd, op};
        illegal = !upper_same(imm, 11);
      end
      FMT_S: begin
        raw     = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        illegal = !upper_same(imm, 11);
      end
      FMT_B: begin
        raw     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        illegal = !upper_same(imm, 12) || imm[0];
      end
      FMT_U: begin
        raw     = {imm[31:12], rd, op};
        illegal = (imm[11:0] != 12'h0);
      end
      FMT_J: begin
        raw     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        illegal = !upper_same(imm, 20) || imm[0];
      end
      FMT_R: begin
        raw     = {f7, rs2, rs1, f3, rd, op};
        illegal = 1'b0;
      end
      default: ;
    endcase
    ins = illegal ? INS_NOP : raw;
    err = illegal;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage instruction encoder: S1 holds the raw request, S2 holds the encoded word with its
// byte address. Also keeps the streaming address counter and a saturating error count.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_f3,
  input  logic [6:0]        in_f7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ins,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic              s1_valid_q, s1_valid_d;
  req_t              s1_req_q, s1_req_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_ins_q, out_ins_d;
  logic              out_err_q, out_err_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic        s2_adv, s1_adv, s2_load;
  logic [31:0] pack_ins;
  logic        pack_err;

  imm_pack u_pack (
    .fmt (s1_req_q.fmt),
    .op  (s1_req_q.op),
    .rd  (s1_req_q.rd),
    .rs1 (s1_req_q.rs1),
    .rs2 (s1_req_q.rs2),
    .f3  (s1_req_q.f3),
    .f7  (s1_req_q.f7),
    .imm (s1_req_q.imm),
    .ins (pack_ins),
    .err (pack_err)
  );

  assign s2_adv  = !out_valid_q || out_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign s2_load = s1_valid_q && s2_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    out_valid_d = out_valid_q;
    out_ins_d   = out_ins_q;
    out_err_d   = out_err_q;
    out_addr_d  = out_addr_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_req_d = '{fmt: in_fmt, op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                     f3: in_f3, f7: in_f7, imm: in_imm};
      end
    end
    if (s2_adv) out_valid_d = s1_valid_q;
    if (s2_load) begin
      out_ins_d  = pack_ins;
      out_err_d  = pack_err;
      out_addr_d = base_load ? base_addr : cnt_q;
    end
  end

  // A base load overrides the increment; a word entering S2 in the same cycle takes the new base.
  always_comb begin
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    if (base_load)    cnt_d = s2_load ? base_addr + ADDR_STEP : base_addr;
    else if (s2_load) cnt_d = cnt_q + ADDR_STEP;
    if (out_valid_q && out_ready && out_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ins_q   <= 32'h0;
      out_err_q   <= 1'b0;
      out_addr_q  <= '0;
      cnt_q       <= '0;
      err_cnt_q   <= 8'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_err_q   <= out_err_d;
      out_addr_q  <= out_addr_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // NOTE: the S1 payload has no reset; it is qualified by s1_valid_q, so its contents after reset never matter.
  always_ff @(posedge clk) begin
    s1_req_q <= s1_req_d;
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_ins   = out_ins_q;
  assign out_err   = out_err_q;
  assign out_addr  = out_addr_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined instruction encoder, the inverse of the immediate extender. It accepts instruction fields plus a full 32-bit immediate and packs them into a 32-bit RV32I instruction word, range-checking the immediate for the selected format. Encoded words are streamed with sequential byte addresses to the instruction-memory loader and self-test paths. Feeding a good output word back through the extender with the same format must return the original immediate.

## Interface
- ADDR_W, 10: width of the byte-address counter on `out_addr`.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when `in_valid && in_ready`.
- in_fmt  in  3  format select; uses the `Ext_ImmI/S/B/U/J` codes from `define.v`, plus new `Enc_R`.
- in_op  in  7  opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_f3  in  3  funct3.
- in_f7  in  7  funct7, R format only.
- in_imm  in  32  signed or raw immediate.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts.
- out_ins  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address assigned to `out_ins`.
- out_err  out  1  immediate illegal or format unknown; `out_ins` is the NOP 0x00000013.
- base_load  in  1  load the address counter.
- base_addr  in  ADDR_W  value for `base_load`.
- err_count  out  8  saturating count of erroneous words handed off.

## Operation
- **Encodings** (`imm` means `in_imm`; output bits listed MSB to LSB):
  - I: imm[11:0], rs1, f3, rd, op.
  - S: imm[11:5], rs2, rs1, f3, imm[4:0], op.
  - B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op.
  - U: imm[31:12], rd, op.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
  - R: f7, rs2, rs1, f3, rd, op. The immediate is ignored and never errors.
- **Legality checks:**
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - Any other `in_fmt` value is an error.
- **On error:** the word is still emitted, with `out_err=1` and `out_ins=0x00000013`.
- **Address counter:**
  - Each word entering stage 2 takes the counter value as its `out_addr`.
  - The counter then advances by 4, modulo 2^ADDR_W.
- **base_load priority:** `base_load` beats the increment.
  - If a word enters stage 2 in the same cycle, that word takes `base_addr` and the counter becomes `base_addr+4`.
  - Otherwise the counter becomes `base_addr`.
- **err_count:** increments on `out_valid && out_ready && out_err` and saturates at 255.

## Timing
- **Pipeline:** two register stages.
  - S1 registers the raw request.
  - Legality check and encoding are combinational from S1.
  - S2 holds `out_ins`, `out_err` and `out_addr`.
  - Latency is 2 cycles from accept to `out_valid`, with no backpressure.
  - Throughput is 1 word per cycle.
- **Advance rules:**
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - The ready path is combinational from `out_ready`; this is accepted.
- **Output stability:** while `out_valid && !out_ready`, `out_ins`, `out_addr` and `out_err` hold stable. No word is dropped or duplicated.
- **Simultaneous handoff and accept:** both happen in the same cycle, with no bubble.
- **Reset values:**
  - All valids 0.
  - `out_ins`=0, `out_addr`=0, `out_err`=0.
  - Counter 0, `err_count` 0.
  - `in_ready`=1 in the first cycle after reset.
- **Reset mid-stream:** in-flight words are discarded; there is no partial output.

## Structure
- `define.v` holds the `Ext_Imm*` codes, the new `Enc_R` code and an `INS_NOP` constant (0x00000013). The extender and this block share them.
- A combinational sub-module `imm_pack` performs fields + format → {ins, err}. It can be reused by the bench for round-trip checks.
- The top level holds the two stage registers, the address counter and the error counter.

## Test plan
- **I-format basic:** I-format, op=0x13, rd=1, rs1=0, f3=0, imm=-1 → `out_ins`=0xFFF00093, err=0, addr=0, two cycles after accept.
- **B-format:** op=0x63, rs1=1, rs2=2, f3=0, imm=8 → 0x00208463.
- **J-format:** op=0x6F, rd=1, imm=0x800 → 0x001000EF.
- **Range errors:**
  - I-format, imm=2048 → err=1, `out_ins`=0x00000013, `err_count`=1 after handoff.
  - U-format, imm=0x12345001 → err=1.
- **U-format good:** op=0x37, rd=5, imm=0x12345000 → 0x123452B7.
- **Streaming and addressing:**
  - Back-to-back stream of 6 words with `out_ready` toggling 1,0,0,1 → words emerge in order, held stable while stalled, with addresses 0, 4, 8, …
  - `base_load`=0x3F8 asserted with a word entering S2 → that word gets 0x3F8. The next two words get 0x3FC, then 0x000 (wrap).
  - `rst` asserted mid-stream → `out_valid`=0 on the next cycle and counters are 0.
